// File: rtl/cpu_pipe_core_if.sv
// Core-side bus bundle: instruction fetch port plus writeback/status observation.
// Latency: none, plain wires; imem_data must answer imem_addr in the same cycle.
// No backpressure: the core never stalls, the ROM is assumed always ready.
interface cpu_pipe_core_if #(
  parameter int DATA_W = 16,
  parameter int PC_W   = 8
);
  logic [PC_W-1:0]   imem_addr;
  logic [15:0]       imem_data;
  logic [15:0]       inst;
  logic              wb_valid;
  logic [3:0]        wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              halted;
  logic [31:0]       retired;

  // the core drives fetch address and all observation outputs
  modport master (
    output imem_addr, inst, wb_valid, wb_rd, wb_data, halted, retired,
    input  imem_data
  );

  // the environment supplies instructions and watches the rest
  modport slave (
    input  imem_addr, inst, wb_valid, wb_rd, wb_data, halted, retired,
    output imem_data
  );
endinterface

// File: rtl/cpu_pipe_core.sv
// Three-stage fetch/decode/execute 16-bit-instruction core; optional retire counter via CPU_PERF_CNT_EN.
// Latency: instruction fetched at edge n writes its register at edge n+2; taken BNZ costs 2 bubbles.
// No backpressure or stalls: E-result bypass into decode, BNZ/HALT in E flush the younger slots.
module cpu_pipe_core #(
  parameter int DATA_W = 16,
  parameter int REG_N  = 16,
  parameter int PC_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  cpu_pipe_core_if.master  bus
);

  localparam int RI_W = (REG_N > 1) ? $clog2(REG_N) : 1;

  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_LI   = 4'h5;
  localparam logic [3:0] OP_ADDI = 4'h6;
  localparam logic [3:0] OP_BNZ  = 4'h7;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic {ST_RUN, ST_HALT} state_t;

  state_t state_q, state_d;

  logic [PC_W-1:0]   pc_q;

  // fetch/decode slot
  logic              fd_vld;
  logic [15:0]       fd_inst;
  logic [PC_W-1:0]   fd_pc;

  // decode/execute slot
  logic              de_vld;
  logic [3:0]        de_op;
  logic [RI_W-1:0]   de_rd;
  logic [DATA_W-1:0] de_a, de_b, de_d, de_sext;
  logic [7:0]        de_imm;
  logic [PC_W-1:0]   de_pc;

  logic [DATA_W-1:0] regs [REG_N];

  logic [3:0]        wb_rd_q;
  logic [DATA_W-1:0] wb_data_q;
  logic              wb_valid_q;

  // decode-side fields and operands
  logic [3:0]        d_op;
  logic [RI_W-1:0]   d_rd, d_rs, d_rt;
  logic [DATA_W-1:0] d_a, d_b, d_d, d_sext;

  // execute-side results
  logic              ex_wr;
  logic [DATA_W-1:0] ex_res;
  logic              br_take, halt_e;
  logic [PC_W-1:0]   br_tgt;
  logic              running;

  assign running = (state_q == ST_RUN);

  // execute: ALU result, register-write qualifier, branch/halt decisions
  always_comb begin
    ex_res  = '0;
    ex_wr   = de_vld && (de_op >= OP_ADD) && (de_op <= OP_ADDI);
    br_take = de_vld && (de_op == OP_BNZ) && (de_d != '0);
    halt_e  = de_vld && (de_op == OP_HALT);
    br_tgt  = de_pc + PC_W'($signed(de_imm));
    case (de_op)
      OP_ADD:  ex_res = de_a + de_b;
      OP_SUB:  ex_res = de_a - de_b;
      OP_AND:  ex_res = de_a & de_b;
      OP_OR:   ex_res = de_a | de_b;
      OP_LI:   ex_res = de_sext;
      OP_ADDI: ex_res = de_d + de_sext;
      default: ex_res = '0;
    endcase
  end

  // decode: field split and operand read with bypass from the E-stage write
  always_comb begin
    d_op   = fd_inst[15:12];
    d_rd   = fd_inst[8 +: RI_W];
    d_rs   = fd_inst[4 +: RI_W];
    d_rt   = fd_inst[0 +: RI_W];
    d_sext = DATA_W'($signed(fd_inst[7:0]));
    d_a    = regs[d_rs];
    d_b    = regs[d_rt];
    d_d    = regs[d_rd];
    if (ex_wr && (de_rd == d_rs)) d_a = ex_res;
    if (ex_wr && (de_rd == d_rt)) d_b = ex_res;
    if (ex_wr && (de_rd == d_rd)) d_d = ex_res;
  end

  // run/halt state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  // HALT reaching E stops the core until reset
  always_comb begin
    state_d = state_q;
    if (state_q == ST_RUN && halt_e) state_d = ST_HALT;
  end

  // PC and pipeline slots: advance, or redirect and flush on BNZ taken / HALT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= '0;
      fd_vld  <= 1'b0;
      fd_inst <= '0;
      fd_pc   <= '0;
      de_vld  <= 1'b0;
      de_op   <= '0;
      de_rd   <= '0;
      de_a    <= '0;
      de_b    <= '0;
      de_d    <= '0;
      de_sext <= '0;
      de_imm  <= '0;
      de_pc   <= '0;
    end else if (running) begin
      if (br_take) begin
        pc_q   <= br_tgt;
        fd_vld <= 1'b0;
        de_vld <= 1'b0;
      end else if (halt_e) begin
        pc_q   <= de_pc + 1'b1;
        fd_vld <= 1'b0;
        de_vld <= 1'b0;
      end else begin
        pc_q    <= pc_q + 1'b1;
        fd_vld  <= 1'b1;
        fd_inst <= bus.imem_data;
        fd_pc   <= pc_q;
        de_vld  <= fd_vld;
        de_op   <= d_op;
        de_rd   <= d_rd;
        de_a    <= d_a;
        de_b    <= d_b;
        de_d    <= d_d;
        de_sext <= d_sext;
        de_imm  <= fd_inst[7:0];
        de_pc   <= fd_pc;
      end
    end
  end

  // register file write and writeback bus at the edge ending E
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_N; i++) regs[i] <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
    end else begin
      wb_valid_q <= running && ex_wr;
      if (running && ex_wr) begin
        regs[de_rd] <= ex_res;
        wb_rd_q     <= 4'(de_rd);
        wb_data_q   <= ex_res;
      end
    end
  end

`ifdef CPU_PERF_CNT_EN
  logic [31:0] retired_q;

  // count every valid instruction leaving E, flushed slots never reach here
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  retired_q <= '0;
    else if (running && de_vld) retired_q <= retired_q + 32'd1;
  end

  assign bus.retired = retired_q;
`else
  assign bus.retired = '0;
`endif

  assign bus.imem_addr = pc_q;
  assign bus.inst      = fd_vld ? fd_inst : 16'h0000;
  assign bus.wb_valid  = wb_valid_q;
  assign bus.wb_rd     = wb_rd_q;
  assign bus.wb_data   = wb_data_q;
  assign bus.halted    = (state_q == ST_HALT);

endmodule
